// File: rtl/cont_ascdesc_param_if.sv
// Control and status bundle for the up/down counter.
// The master drives the count controls. The slave returns the count and its flags.
interface cont_ascdesc_param_if #(parameter int WIDTH = 3);
  logic             en;
  logic             updown;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] Q;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  modport master (output en, updown, load, din,
                  input  Q, full, empty, ovf, unf);
  modport slave  (input  en, updown, load, din,
                  output Q, full, empty, ovf, unf);
endinterface

// File: rtl/cont_ascdesc_param.sv
// Up/down counter with a terminal count of MAX, a clamped parallel load, and wrap or saturate behaviour.
// Attempts to count past either limit produce a one-cycle ovf or unf pulse.
module cont_ascdesc_param #(
  parameter int WIDTH = 3,
  parameter int MAX   = 7,
  parameter int WRAP  = 1
) (
  input logic                 clk,
  input logic                 reset,
  cont_ascdesc_param_if.slave bus
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt;
  logic             ovf_r, unf_r;
  logic             at_max, at_zero;

  assign at_max  = (cnt == MAXV);
  assign at_zero = (cnt == '0);

  // The limit compares come before any +1 or -1, so the count never passes MAX, even when MAX is the all-ones value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
      if (bus.load) begin
        cnt <= (bus.din > MAXV) ? MAXV : bus.din;
      end else if (bus.en) begin
        if (bus.updown) begin
          if (at_max) begin
            ovf_r <= 1'b1;
            if (WRAP != 0) cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          if (at_zero) begin
            unf_r <= 1'b1;
            if (WRAP != 0) cnt <= MAXV;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      end
    end
  end

  assign bus.Q     = cnt;
  assign bus.full  = at_max;
  assign bus.empty = at_zero;
  assign bus.ovf   = ovf_r;
  assign bus.unf   = unf_r;
endmodule

// File: tb/tb_cont_ascdesc_param.sv
// Scoreboard bench that drives three counter configurations from one stimulus stream.
// The configurations are: wrap at 7, saturate at 5, and saturate at 15 with a 4-bit count.
module tb_cont_ascdesc_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cont_ascdesc_param_if #(.WIDTH(3)) b0();
  cont_ascdesc_param_if #(.WIDTH(3)) b1();
  cont_ascdesc_param_if #(.WIDTH(4)) b2();

  cont_ascdesc_param #(.WIDTH(3), .MAX(7),  .WRAP(1)) d0 (.clk(clk), .reset(rst), .bus(b0.slave));
  cont_ascdesc_param #(.WIDTH(3), .MAX(5),  .WRAP(0)) d1 (.clk(clk), .reset(rst), .bus(b1.slave));
  cont_ascdesc_param #(.WIDTH(4), .MAX(15), .WRAP(0)) d2 (.clk(clk), .reset(rst), .bus(b2.slave));

  typedef struct {
    int q;
    bit ovf, unf, full, empty;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   m0, m1, m2;
  int   nchk = 0, npass = 0;
  bit   started = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic exp_t nxt(input int q, input bit rn, en, ud, ld, input int din,
                               input int mx, input bit wrap);
    exp_t e;
    e.q = q; e.ovf = 0; e.unf = 0;
    if (!rn)     e.q = 0;
    else if (ld) e.q = (din > mx) ? mx : din;
    else if (en) begin
      if (ud) begin
        if (q == mx) begin e.ovf = 1; e.q = wrap ? 0 : mx; end
        else e.q = q + 1;
      end else begin
        if (q == 0) begin e.unf = 1; e.q = wrap ? mx : 0; end
        else e.q = q - 1;
      end
    end
    e.full  = (e.q == mx);
    e.empty = (e.q == 0);
    return e;
  endfunction

  task automatic cmp(input string n, input exp_t e, input logic [15:0] q,
                     input logic o, u, f, em);
    chk({n, ".Q"},     q,  e.q);
    chk({n, ".ovf"},   o,  e.ovf);
    chk({n, ".unf"},   u,  e.unf);
    chk({n, ".full"},  f,  e.full);
    chk({n, ".empty"}, em, e.empty);
  endtask

  task automatic step(input bit rn, en, ud, ld, input int din);
    logic [3:0] d4;
    exp_t e;
    d4 = din[3:0];
    rst = rn;
    b0.en = en; b0.updown = ud; b0.load = ld; b0.din = d4[2:0];
    b1.en = en; b1.updown = ud; b1.load = ld; b1.din = d4[2:0];
    b2.en = en; b2.updown = ud; b2.load = ld; b2.din = d4;
    // Outputs must not move between edges, whatever reset and the controls do.
    if (started) begin
      #2;
      chk("hold0.Q", b0.Q, m0);
      chk("hold1.Q", b1.Q, m1);
      chk("hold2.Q", b2.Q, m2);
    end
    e = nxt(m0, rn, en, ud, ld, int'(d4[2:0]), 7, 1);  q0.push_back(e); m0 = e.q;
    e = nxt(m1, rn, en, ud, ld, int'(d4[2:0]), 5, 0);  q1.push_back(e); m1 = e.q;
    e = nxt(m2, rn, en, ud, ld, int'(d4),      15, 0); q2.push_back(e); m2 = e.q;
    @(posedge clk); #1;
    cmp("d0", q0.pop_front(), 16'(b0.Q), b0.ovf, b0.unf, b0.full, b0.empty);
    cmp("d1", q1.pop_front(), 16'(b1.Q), b1.ovf, b1.unf, b1.full, b1.empty);
    cmp("d2", q2.pop_front(), 16'(b2.Q), b2.ovf, b2.unf, b2.full, b2.empty);
    started = 1;
  endtask

  initial begin
    m0 = 0; m1 = 0; m2 = 0;
    step(0, 0, 0, 0, 0);                       // reset state
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0);  // wrap 7->0, saturate at 5
    step(1, 0, 0, 1, 2);                       // load 2
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);   // down through 0
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0);   // saturation attempts
    step(1, 1, 1, 1, 7);                       // load wins over en, clamped
    step(1, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);   // reach 4
    step(0, 1, 1, 1, 2);                       // reset overrides load and en
    step(1, 1, 1, 0, 0);                       // resume at 1
    for (int i = 0; i < 5; i++) step(1, 0, bit'(i % 2), 0, 0);  // idle
    step(1, 0, 0, 1, 15);                      // full-range limit on the 4-bit count
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 19) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/cont_ascdesc_param.md
CONT_ASCDESC_PARAM -- requirements
Module: cont_ascdesc_param

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits; legal range 2..16.
REQ-002 Parameter MAX, default 7: terminal count; legal range 1..2**WIDTH-1.
REQ-003 Parameter WRAP, default 1: 1 = wrap at the limits, 0 = saturate at the limits.
REQ-004 clk  input  1: sole clock; all state updates on the rising edge.
REQ-005 reset  input  1: synchronous, active-low reset.
REQ-006 en  input  1: count enable.
REQ-007 updown  input  1: direction; 1 = up, 0 = down.
REQ-008 load  input  1: synchronous parallel load strobe.
REQ-009 din  input  WIDTH: load value.
REQ-010 Q  output  WIDTH: registered count value.
REQ-011 full  output  1: high while Q == MAX.
REQ-012 empty  output  1: high while Q == 0.
REQ-013 ovf  output  1: registered one-cycle pulse on an up-count attempt at MAX.
REQ-014 unf  output  1: registered one-cycle pulse on a down-count attempt at 0.

Function
REQ-015 The block SHALL apply this per-edge priority: reset low, then load, then en; with none active, Q, ovf and unf SHALL hold or clear as REQ-022 states.
REQ-016 On load, the block SHALL set Q to din when din <= MAX, else to MAX (clamp); updown and en SHALL be ignored that cycle.
REQ-017 On en=1, updown=1 and Q < MAX, the block SHALL set Q to Q+1.
REQ-018 On en=1, updown=1 and Q == MAX, the block SHALL set Q to 0 if WRAP=1, or hold MAX if WRAP=0, and SHALL assert ovf on the next cycle.
REQ-019 On en=1, updown=0 and Q > 0, the block SHALL set Q to Q-1.
REQ-020 On en=1, updown=0 and Q == 0, the block SHALL set Q to MAX if WRAP=1, or hold 0 if WRAP=0, and SHALL assert unf on the next cycle.
REQ-021 With en=0 and load=0, the block SHALL hold Q.
REQ-022 ovf and unf SHALL be high for exactly one cycle per triggering edge; on any edge without a triggering event, including load and idle edges, they SHALL return to 0.
REQ-023 full and empty SHALL be combinational decodes of Q, with zero latency relative to Q.
REQ-024 Q SHALL never exceed MAX under any input sequence.
REQ-025 All arithmetic SHALL be performed in WIDTH bits; Q+1 with Q == MAX SHALL never be taken even when MAX == 2**WIDTH-1.
REQ-026 A change on updown SHALL take effect on the same edge it is sampled, with no extra pipeline stage.

Reset
REQ-027 While reset is low at a rising edge, the block SHALL set Q=0, ovf=0 and unf=0, overriding load and en.
REQ-028 After reset, empty SHALL be 1 and full SHALL be 0.
REQ-029 A reset asserted mid-count SHALL take effect on the next rising edge with no partial update; counting SHALL resume on the first edge with reset high.
REQ-030 Reset SHALL have no asynchronous effect; outputs SHALL not change between clock edges.

Verification
REQ-031 Default parameters, reset low 1 cycle, then en=1 and updown=1 for 10 cycles -> Q = 1,2,...,7,0,1,2; ovf high for exactly the cycle after the 7->0 transition; full high only while Q=7.
REQ-032 Default parameters, Q=2, then updown=0 for 4 cycles -> Q = 1,0,7,6; unf pulses once after the 0->7 transition; empty high only while Q=0.
REQ-033 WRAP=0 and MAX=5, up-count for 8 cycles from 0 -> Q = 1..5, then holds 5; ovf pulses on each of the 3 attempts at 5; Q never reaches 6 or 7.
REQ-034 MAX=5, load=1 with din=7 and en=1, updown=1 -> Q=5 next cycle, ovf=0; load with din=3 -> Q=3.
REQ-035 Counting up with Q=4, reset low together with load=1 and din=2 -> Q=0, ovf=0 and unf=0 next cycle; reset high -> counting resumes with Q=1.
REQ-036 en=0 for 5 cycles while updown toggles -> Q, ovf and unf are unchanged or 0 throughout.
